// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache-to-RAM arbiter: word type, RAM status and grant FSM states.
// Latency: n/a (types and a helper function only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    // Status reported by the RAM model/controller on its single port.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Grant FSM: idle, dcache granted, icache granted.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } arb_state_t;

    // RAM has finished the current word, either successfully or with an error.
    function automatic logic ram_finished(ramstate_t s);
        return (s == ACCESS) || (s == ERROR);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of icache, dcache and RAM-port signals seen by the memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: iwait/dwait stall each cache; ramstate paces the RAM side.
// Modports: slave = arbiter view, master = caches + RAM (or a testbench) view.
interface mem_arbiter_if;

    // icache side
    logic                        iREN;
    mem_arbiter_pkg::word_t      iaddr;
    mem_arbiter_pkg::word_t      iload;
    logic                        iwait;

    // dcache side
    logic                        dREN;
    logic                        dWEN;
    mem_arbiter_pkg::word_t      daddr;
    mem_arbiter_pkg::word_t      dstore;
    mem_arbiter_pkg::word_t      dload;
    logic                        dwait;

    // RAM side
    logic                        ramREN;
    logic                        ramWEN;
    mem_arbiter_pkg::word_t      ramaddr;
    mem_arbiter_pkg::word_t      ramstore;
    mem_arbiter_pkg::word_t      ramload;
    mem_arbiter_pkg::ramstate_t  ramstate;

    // sticky error flag
    logic                        err;

    modport slave (
        input  iREN, iaddr,
        input  dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iload, iwait,
        output dload, dwait,
        output ramREN, ramWEN, ramaddr, ramstore,
        output err
    );

    modport master (
        output iREN, iaddr,
        output dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iload, iwait,
        input  dload, dwait,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  err
    );

endinterface

// File: rtl/mem_arbiter_flex_counter.sv
// Loadable-rollover up counter with synchronous clear; used as the transaction watchdog.
// Latency: count updates one cycle after enable; rollover_flag is combinational from count.
// Backpressure: none; counts whenever enabled.
// Ports: clk, rst (sync, active-high), clear (sync, wins over enable), count_enable,
//        rollover_val (terminal value), count_out, rollover_flag (count_out == rollover_val).
module mem_arbiter_flex_counter #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            count_enable,
    input  logic [BITS-1:0] rollover_val,
    output logic [BITS-1:0] count_out,
    output logic            rollover_flag
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_out <= '0;
            end else begin
                count_out <= count_out + 1'b1;
            end
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache single-word requests onto one RAM port with a timeout watchdog and sticky err.
// Latency: grant registered (first RAM strobe the cycle after the request); data/wait combinational once granted.
// Backpressure: losing requester held at wait=1; granted wait drops for exactly the completing cycle.
// Ports: CLK, RST (sync, active-high); bus (mem_arbiter_if.slave) carries icache, dcache, RAM and err signals.
// Parameters: TIMEOUT (max grant cycles, >= 2), CTW (counter width, 2**CTW > TIMEOUT).
// Build option: define MEM_RR_EN for round-robin between caches; otherwise the dcache always wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CTW     = 8
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    arb_state_t     state;
    arb_state_t     next_state;
    logic           lastd;
    logic           err_q;

    logic           d_req;
    logic           i_req;
    logic           req_live;
    logic           in_grant;
    logic           done;
    logic           tfire;
    logic [CTW-1:0] tcount;

    assign d_req = bus.dREN | bus.dWEN;
    assign i_req = bus.iREN;

    assign in_grant = (state == DGNT) || (state == IGNT);

    // Granted requester still asking; if it drops, the transaction is aborted silently.
    always_comb begin
        req_live = 1'b0;
        case (state)
            DGNT:    req_live = d_req;
            IGNT:    req_live = i_req;
            default: req_live = 1'b0;
        endcase
    end

    // Completion needs a live request; an abort never produces a wait pulse.
    assign done = req_live & (ram_finished(bus.ramstate) | tfire);

    // Watchdog: counts grant cycles; tfire marks the last permitted one (count == TIMEOUT-1).
    mem_arbiter_flex_counter #(
        .BITS (CTW)
    ) u_timeout (
        .clk          (CLK),
        .rst          (RST),
        .clear        ((state == IDLE) | done),
        .count_enable (in_grant),
        .rollover_val (CTW'(TIMEOUT - 1)),
        .count_out    (tcount),
        .rollover_flag(tfire)
    );

    // State register plus the grant-history and sticky-error bits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            lastd <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (done) begin
                lastd <= (state == DGNT);
                if ((bus.ramstate == ERROR) || tfire) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
`ifdef MEM_RR_EN
                if (d_req && i_req) begin
                    next_state = lastd ? IGNT : DGNT;
                end else if (d_req) begin
                    next_state = DGNT;
                end else if (i_req) begin
                    next_state = IGNT;
                end
`else
                if (d_req) begin
                    next_state = DGNT;
                end else if (i_req) begin
                    next_state = IGNT;
                end
`endif
            end
            // Completion or abort both return to IDLE, forcing a bubble between transactions.
            DGNT: if (!req_live || done) next_state = IDLE;
            IGNT: if (!req_live || done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifndef MEM_RR_EN
    // Grant history is kept in every build but only steers arbitration with round-robin.
    logic unused_lastd;
    assign unused_lastd = lastd;
`endif

    // Output logic: RAM port follows the granted cache's live inputs so block fills
    // and writebacks stream one word per RAM access without an extra register stage.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        case (state)
            DGNT: begin
                bus.ramREN   = bus.dREN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dload    = bus.ramload;
                bus.dwait    = ~done;
            end
            IGNT: begin
                bus.ramREN   = bus.iREN;
                bus.ramaddr  = bus.iaddr;
                bus.iload    = bus.ramload;
                bus.iwait    = ~done;
            end
            default: begin
            end
        endcase
    end

    assign bus.err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic CLK;
    logic RST;
    int   nvec;
    int   nerr;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .TIMEOUT (64),
        .CTW     (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to 1 time unit after the next rising edge; inputs are then changed and
    // outputs sampled a further #1 later, well away from the active edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.iREN = 1'b0; bus.iaddr = 32'h0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'h0; bus.dstore = 32'h0;
        bus.ramload = 32'h5555_5555; bus.ramstate = FREE;
        cyc(); cyc(); #1;
        nvec++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.err} !== 5'b00110) begin
            nerr++;
            $display("FAIL reset_ctrl: got %b want 00110", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.err});
        end
        nvec++;
        if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== 128'h0) begin
            nerr++;
            $display("FAIL reset_data: got %h want 0", {bus.ramaddr, bus.ramstore, bus.iload, bus.dload});
        end
        RST = 1'b0;
    endtask

    // dcache read: BUSY, BUSY, ACCESS.
    task automatic test_dread();
        cyc();
        bus.dREN = 1'b1; bus.daddr = 32'h100; bus.ramstate = FREE; #1;
        nvec++;
        if ({bus.ramREN, bus.dwait} !== 2'b01) begin
            nerr++; $display("FAIL dread_req_cycle: got %b want 01", {bus.ramREN, bus.dwait});
        end
        for (int n = 1; n <= 2; n++) begin
            cyc();
            bus.ramstate = BUSY; #1;
            nvec++;
            if ({bus.ramREN, bus.ramWEN, bus.dwait, bus.iwait} !== 4'b1011 || bus.ramaddr !== 32'h100) begin
                nerr++;
                $display("FAIL dread_busy%0d: got %b addr %h want 1011 addr 00000100", n,
                         {bus.ramREN, bus.ramWEN, bus.dwait, bus.iwait}, bus.ramaddr);
            end
        end
        cyc();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEAD_BEEF; #1;
        nvec++;
        if ({bus.ramREN, bus.dwait, bus.iwait} !== 3'b101 || bus.dload !== 32'hDEAD_BEEF) begin
            nerr++;
            $display("FAIL dread_access: got %b dload %h want 101 dload deadbeef",
                     {bus.ramREN, bus.dwait, bus.iwait}, bus.dload);
        end
        cyc();
        bus.ramstate = FREE; #1;
        nvec++;
        if ({bus.ramREN, bus.dwait, bus.err} !== 3'b010) begin
            nerr++; $display("FAIL dread_bubble: got %b want 010", {bus.ramREN, bus.dwait, bus.err});
        end
        bus.dREN = 1'b0;
    endtask

    // Simultaneous dcache write and icache read: dcache first, bubble, then icache.
    task automatic test_write_then_iread();
        cyc();
        bus.dWEN = 1'b1; bus.iREN = 1'b1; bus.daddr = 32'h40; bus.dstore = 32'h1234_5678;
        bus.iaddr = 32'h0; #1;
        cyc();
        bus.ramstate = BUSY; #1;
        nvec++;
        if ({bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait} !== 4'b1011 ||
            bus.ramstore !== 32'h1234_5678 || bus.ramaddr !== 32'h40) begin
            nerr++;
            $display("FAIL wr_busy: got %b store %h addr %h want 1011 store 12345678 addr 00000040",
                     {bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait}, bus.ramstore, bus.ramaddr);
        end
        cyc();
        bus.ramstate = ACCESS; #1;
        nvec++;
        if ({bus.ramWEN, bus.dwait, bus.iwait} !== 3'b101) begin
            nerr++; $display("FAIL wr_access: got %b want 101", {bus.ramWEN, bus.dwait, bus.iwait});
        end
        cyc();
        bus.dWEN = 1'b0; bus.ramstate = FREE; #1;
        nvec++;
        if ({bus.ramWEN, bus.ramREN, bus.iwait, bus.dwait} !== 4'b0011) begin
            nerr++; $display("FAIL wr_bubble: got %b want 0011", {bus.ramWEN, bus.ramREN, bus.iwait, bus.dwait});
        end
        cyc();
        bus.ramstate = BUSY; #1;
        nvec++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 4'b1011 || bus.ramaddr !== 32'h0) begin
            nerr++;
            $display("FAIL ird_busy: got %b addr %h want 1011 addr 00000000",
                     {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, bus.ramaddr);
        end
        cyc();
        bus.ramstate = ACCESS; bus.ramload = 32'hCAFE_F00D; #1;
        nvec++;
        if ({bus.iwait, bus.dwait} !== 2'b01 || bus.iload !== 32'hCAFE_F00D || bus.dload !== 32'h0) begin
            nerr++;
            $display("FAIL ird_access: got %b iload %h dload %h want 01 cafef00d 00000000",
                     {bus.iwait, bus.dwait}, bus.iload, bus.dload);
        end
        cyc();
        bus.iREN = 1'b0; bus.ramstate = FREE; #1;
        nvec++;
        if ({bus.ramREN, bus.iwait} !== 2'b01) begin
            nerr++; $display("FAIL ird_done: got %b want 01", {bus.ramREN, bus.iwait});
        end
    endtask

    // Both caches hold requests with instant ACCESS; previous grant was icache.
    task automatic test_arbitration();
        logic [31:0] exp_addr [4];
`ifdef MEM_RR_EN
        exp_addr = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};
`else
        exp_addr = '{32'hA0, 32'hA0, 32'hA0, 32'hA0};
`endif
        cyc();
        bus.dREN = 1'b1; bus.iREN = 1'b1; bus.daddr = 32'hA0; bus.iaddr = 32'hB0;
        bus.ramstate = ACCESS; #1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_waits;
            exp_waits = (exp_addr[k] == 32'hA0) ? 2'b10 : 2'b01;
            cyc(); #1;
            nvec++;
            if (bus.ramREN !== 1'b1 || bus.ramaddr !== exp_addr[k] || {bus.iwait, bus.dwait} !== exp_waits) begin
                nerr++;
                $display("FAIL arb_grant%0d: ren %b addr %h waits %b want 1 %h %b", k,
                         bus.ramREN, bus.ramaddr, {bus.iwait, bus.dwait}, exp_addr[k], exp_waits);
            end
            cyc(); #1;
            nvec++;
            if ({bus.ramREN, bus.iwait, bus.dwait} !== 3'b011) begin
                nerr++; $display("FAIL arb_bubble%0d: got %b want 011", k, {bus.ramREN, bus.iwait, bus.dwait});
            end
        end
        bus.dREN = 1'b0; bus.iREN = 1'b0; bus.ramstate = FREE;
    endtask

    // dcache drops its request while granted: silent abort.
    task automatic test_abort();
        cyc();
        bus.dREN = 1'b1; bus.daddr = 32'h300; #1;
        cyc();
        bus.ramstate = BUSY; #1;
        nvec++;
        if ({bus.ramREN, bus.dwait} !== 2'b11) begin
            nerr++; $display("FAIL abort_grant: got %b want 11", {bus.ramREN, bus.dwait});
        end
        cyc();
        bus.dREN = 1'b0; #1;
        nvec++;
        if ({bus.ramREN, bus.ramWEN, bus.dwait, bus.iwait} !== 4'b0011) begin
            nerr++; $display("FAIL abort_drop: got %b want 0011", {bus.ramREN, bus.ramWEN, bus.dwait, bus.iwait});
        end
        // Re-request: must be in IDLE (no strobe this cycle) and granted next cycle.
        cyc();
        bus.dREN = 1'b1; #1;
        nvec++;
        if ({bus.ramREN, bus.dwait, bus.err} !== 3'b010) begin
            nerr++; $display("FAIL abort_idle: got %b want 010", {bus.ramREN, bus.dwait, bus.err});
        end
        cyc();
        bus.ramstate = ACCESS; #1;
        nvec++;
        if ({bus.ramREN, bus.dwait} !== 2'b10) begin
            nerr++; $display("FAIL abort_regrant: got %b want 10", {bus.ramREN, bus.dwait});
        end
        cyc();
        bus.dREN = 1'b0; bus.ramstate = FREE; #1;
    endtask

    // Reset in the middle of a dcache BUSY transaction.
    task automatic test_reset_mid();
        bus.dREN = 1'b1; bus.daddr = 32'h400; #1;
        cyc();
        bus.ramstate = BUSY; #1;
        nvec++;
        if (bus.ramREN !== 1'b1) begin
            nerr++; $display("FAIL rstmid_grant: got %b want 1", bus.ramREN);
        end
        RST = 1'b1;
        cyc(); #1;
        nvec++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.err} !== 5'b00110) begin
            nerr++;
            $display("FAIL rstmid_idle: got %b want 00110", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.err});
        end
        RST = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
        cyc(); #1;
    endtask

    // icache request with RAM stuck BUSY: forced completion on the 64th grant cycle.
    task automatic test_timeout();
        bus.iREN = 1'b1; bus.iaddr = 32'h200; bus.ramstate = BUSY; #1;
        for (int n = 1; n <= 64; n++) begin
            logic exp_iwait;
            exp_iwait = (n == 64) ? 1'b0 : 1'b1;
            cyc(); #1;
            nvec++;
            if ({bus.ramREN, bus.iwait, bus.err} !== {1'b1, exp_iwait, 1'b0}) begin
                nerr++;
                $display("FAIL timeout_cyc%0d: got %b want %b", n, {bus.ramREN, bus.iwait, bus.err},
                         {1'b1, exp_iwait, 1'b0});
            end
        end
        cyc();
        bus.iREN = 1'b0; bus.ramstate = FREE; #1;
        nvec++;
        if ({bus.ramREN, bus.iwait, bus.err} !== 3'b011) begin
            nerr++; $display("FAIL timeout_err: got %b want 011", {bus.ramREN, bus.iwait, bus.err});
        end
        // A clean transaction afterwards leaves err set.
        cyc();
        bus.dREN = 1'b1; #1;
        cyc();
        bus.ramstate = ACCESS; #1;
        cyc();
        bus.dREN = 1'b0; bus.ramstate = FREE; #1;
        nvec++;
        if (bus.err !== 1'b1) begin
            nerr++; $display("FAIL err_sticky: got %b want 1", bus.err);
        end
        RST = 1'b1;
        cyc(); #1;
        RST = 1'b0;
        nvec++;
        if (bus.err !== 1'b0) begin
            nerr++; $display("FAIL err_cleared: got %b want 0", bus.err);
        end
    endtask

    // RAM reports ERROR: completes the transaction and sets err.
    task automatic test_ram_error();
        cyc();
        bus.dREN = 1'b1; bus.daddr = 32'h500; #1;
        cyc();
        bus.ramstate = ERROR; #1;
        nvec++;
        if ({bus.dwait, bus.err} !== 2'b00) begin
            nerr++; $display("FAIL ramerr_done: got %b want 00", {bus.dwait, bus.err});
        end
        cyc();
        bus.dREN = 1'b0; bus.ramstate = FREE; #1;
        nvec++;
        if ({bus.ramREN, bus.dwait, bus.err} !== 3'b011) begin
            nerr++; $display("FAIL ramerr_sticky: got %b want 011", {bus.ramREN, bus.dwait, bus.err});
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_dread();
        test_write_then_iread();
        test_arbitration();
        test_abort();
        test_reset_mid();
        test_timeout();
        test_ram_error();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
